// File: rtl/ds_pkg.sv
// Shared types and width helpers for the block-averaging downsample engine.
package ds_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ds_state_e;

    // Sum of F*F pixels of data_w bits needs 2*log2(F) extra bits
    function automatic int acc_w(input int data_w, input int factor_log2);
        return data_w + 2 * factor_log2;
    endfunction

    // Half of F*F, so the final right shift rounds to nearest
    function automatic int round_const(input int factor_log2);
        return (factor_log2 == 0) ? 0 : (1 << (2 * factor_log2 - 1));
    endfunction

endpackage

// File: rtl/ds_if.sv
// Job control and single-port DRAM handshake bundle for ds_engine.
interface ds_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DIM_W  = 9
);
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [DIM_W-1:0]  img_w;
    logic [DIM_W-1:0]  img_h;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, src_base, dst_base, img_w, img_h, mem_rdata, mem_ready,
        output mem_addr, mem_rd, mem_wr, mem_wdata, busy, done
    );

    modport slave (
        output start, src_base, dst_base, img_w, img_h, mem_rdata, mem_ready,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, done
    );
endinterface

// File: rtl/ds_addr_gen.sv
// Block/pixel counters and incremental source/destination pointers; no multipliers.
module ds_addr_gen
    import ds_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DIM_W       = 9,
    parameter int FACTOR_LOG2 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              rd_step,
    input  logic              wr_step,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              last_pix,
    output logic              last_blk
);
    localparam int K_W = (FACTOR_LOG2 > 0) ? FACTOR_LOG2 : 1;
    localparam logic [K_W-1:0]    K_LAST   = K_W'((1 << FACTOR_LOG2) - 1);
    localparam logic [ADDR_W-1:0] BLK_STEP = ADDR_W'(1 << FACTOR_LOG2);

    logic [K_W-1:0]    kx, ky;
    logic [DIM_W-1:0]  ox, oy;
    logic [DIM_W-1:0]  out_w_q, out_h_q;
    logic [ADDR_W-1:0] img_w_q;
    logic [ADDR_W-1:0] line_ptr, blk_ptr, row_ptr, dst_ptr;
    logic              last_col;

    // line_ptr: first pixel of the current block row; blk_ptr: block origin;
    // row_ptr: start of the current pixel row inside the block
    assign src_addr = row_ptr + ADDR_W'(kx);
    assign dst_addr = dst_ptr;
    assign last_pix = (kx == K_LAST) && (ky == K_LAST);
    assign last_col = (ox == out_w_q - DIM_W'(1));
    assign last_blk = last_col && (oy == out_h_q - DIM_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            kx       <= '0;
            ky       <= '0;
            ox       <= '0;
            oy       <= '0;
            out_w_q  <= '0;
            out_h_q  <= '0;
            img_w_q  <= '0;
            line_ptr <= '0;
            blk_ptr  <= '0;
            row_ptr  <= '0;
            dst_ptr  <= '0;
        end else if (load) begin
            kx       <= '0;
            ky       <= '0;
            ox       <= '0;
            oy       <= '0;
            out_w_q  <= img_w >> FACTOR_LOG2;
            out_h_q  <= img_h >> FACTOR_LOG2;
            img_w_q  <= ADDR_W'(img_w);
            line_ptr <= src_base;
            blk_ptr  <= src_base;
            row_ptr  <= src_base;
            dst_ptr  <= dst_base;
        end else if (rd_step) begin
            if (kx == K_LAST) begin
                kx <= '0;
                if (ky == K_LAST) begin
                    ky <= '0;
                end else begin
                    ky      <= ky + 1'b1;
                    row_ptr <= row_ptr + img_w_q;
                end
            end else begin
                kx <= kx + 1'b1;
            end
        end else if (wr_step) begin
            dst_ptr <= dst_ptr + 1'b1;
            if (last_col) begin
                ox       <= '0;
                oy       <= oy + 1'b1;
                line_ptr <= line_ptr + (img_w_q << FACTOR_LOG2);
                blk_ptr  <= line_ptr + (img_w_q << FACTOR_LOG2);
                row_ptr  <= line_ptr + (img_w_q << FACTOR_LOG2);
            end else begin
                ox      <= ox + 1'b1;
                blk_ptr <= blk_ptr + BLK_STEP;
                row_ptr <= blk_ptr + BLK_STEP;
            end
        end
    end

endmodule

// File: rtl/ds_engine.sv
// Fixed-function F x F block-average downsampler sharing a wait-state DRAM port.
// state | meaning
// IDLE  | waiting for start; latches job geometry
// READ  | fetching one source pixel of the current block
// WRITE | storing the rounded block average
// DONE  | one-cycle completion pulse
module ds_engine
    import ds_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int DIM_W       = 9,
    parameter int FACTOR_LOG2 = 1
) (
    input logic  clk,
    input logic  rst,
    ds_if.master bus
);
    localparam int ACC_W = acc_w(DATA_W, FACTOR_LOG2);
    localparam int SHIFT = 2 * FACTOR_LOG2;
    localparam logic [ACC_W-1:0] RND_V = ACC_W'(round_const(FACTOR_LOG2));

    ds_state_e         state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_sum, acc_rnd;
    logic [DATA_W-1:0] wdata_q;
    logic              load, rd_step, wr_step;
    logic              degenerate;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic              last_pix, last_blk;

    ds_addr_gen #(
        .ADDR_W      (ADDR_W),
        .DIM_W       (DIM_W),
        .FACTOR_LOG2 (FACTOR_LOG2)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .rd_step  (rd_step),
        .wr_step  (wr_step),
        .src_base (bus.src_base),
        .dst_base (bus.dst_base),
        .img_w    (bus.img_w),
        .img_h    (bus.img_h),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .last_pix (last_pix),
        .last_blk (last_blk)
    );

    assign degenerate = ((bus.img_w >> FACTOR_LOG2) == '0) || ((bus.img_h >> FACTOR_LOG2) == '0);
    assign acc_sum    = acc + ACC_W'(bus.mem_rdata);
    assign acc_rnd    = acc_sum + RND_V;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes and address come straight from state so they hold across wait states
    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        rd_step       = 1'b0;
        wr_step       = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = wdata_q;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = degenerate ? DONE : READ;
                end
            end
            READ: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = src_addr;
                bus.busy     = 1'b1;
                if (bus.mem_ready) begin
                    rd_step = 1'b1;
                    if (last_pix) state_nxt = WRITE;
                end
            end
            WRITE: begin
                bus.mem_wr   = 1'b1;
                bus.mem_addr = dst_addr;
                bus.busy     = 1'b1;
                if (bus.mem_ready) begin
                    wr_step   = 1'b1;
                    state_nxt = last_blk ? DONE : READ;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The average is formed on the last read so it is ready in the first WRITE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            wdata_q <= '0;
        end else if (load) begin
            acc <= '0;
        end else if (rd_step) begin
            acc <= acc_sum;
            if (last_pix) wdata_q <= DATA_W'(acc_rnd >> SHIFT);
        end else if (wr_step) begin
            acc <= '0;
        end
    end

endmodule

// File: doc/ds_engine.md
# ds_engine

Parametrised hardware downsampling engine that replaces the microcoded software loop of the downsampling processor with a fixed-function datapath. It reads an 8-bit row-major image from DRAM and averages each F×F block (F = 2^FACTOR_LOG2) with rounding. It writes the downsampled image back to DRAM. It sits beside the processor on the same DRAM port and adds runtime image geometry and a wait-state memory handshake.

## Interface
- ADDR_W, 16, DRAM address width; all addresses wrap modulo 2^ADDR_W
- DATA_W, 8, pixel width
- DIM_W, 9, width of image dimension inputs
- FACTOR_LOG2, 1, log2 of downsample factor F (0..3); FACTOR_LOG2=0 is a plain copy
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin job; sampled only in IDLE
- src_base  in  ADDR_W  address of source pixel (0,0); latched on accepted start
- dst_base  in  ADDR_W  address of output pixel (0,0); latched on accepted start
- img_w, img_h  in  DIM_W  source dimensions in pixels; latched on accepted start
- mem_addr  out  ADDR_W  DRAM address
- mem_rd  out  1  read request
- mem_wr  out  1  write request
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1 during a read
- mem_ready  in  1  DRAM accepts/completes the current access this cycle
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse

## Operation
- Output size: out_w = img_w >> FACTOR_LOG2, out_h = img_h >> FACTOR_LOG2. Trailing source columns and rows that do not fill a block are never read.
- FSM states:
  - IDLE: on start, latch inputs and clear counters. If out_w==0 or out_h==0, go to DONE. Otherwise go to READ.
  - READ: mem_rd=1, mem_addr = current source pixel. On mem_ready, acc += mem_rdata and advance kx (then ky). After block pixel F²−1 is accepted, go to WRITE.
  - WRITE: mem_wr=1, mem_addr = dst_base + out_idx, mem_wdata = (acc + 2^(2·FACTOR_LOG2−1)) >> 2·FACTOR_LOG2, with a rounding term of 0 when FACTOR_LOG2=0. On mem_ready, clear acc and advance ox (then oy). Go to DONE after the last output, otherwise to READ.
  - DONE: done=1 for one cycle, then IDLE.
- Read order:
  - Inner kx, then ky, within the block.
  - Blocks ordered ox, then oy.
  - Source address = src_base + (oy·F+ky)·img_w + ox·F + kx. It is computed with incremental row/column pointers; no multipliers.
- Accumulator width is DATA_W+2·FACTOR_LOG2 and never overflows. An all-max block yields 2^DATA_W−1.
- One outstanding access at a time. mem_rd/mem_wr, mem_addr and mem_wdata stay stable until the cycle mem_ready=1. mem_rd and mem_wr are never high together.
- mem_ready outside READ/WRITE is ignored. start while not IDLE is ignored.
- Reset at any point: next cycle state=IDLE, all outputs 0, acc and counters cleared. An in-flight access is abandoned.

## Timing
- Reset values: mem_addr=0, mem_rd=0, mem_wr=0, mem_wdata=0, busy=0, done=0.
- With start high in cycle 0 (accepted at the end of cycle 0):
  - busy=1 from cycle 1 through the final write-accept cycle, low again when done=1.
  - The first mem_rd is in cycle 1.
- With mem_ready tied high, each output takes F²+1 cycles. The last write is in cycle P·(F²+1), where P = out_w·out_h. done=1 in cycle P·(F²+1)+1.
- Each wait cycle (mem_ready=0) adds exactly one cycle.
- Degenerate job: done=1 in cycle 1, busy=0 throughout, no memory access.
- mem_wdata is registered and valid in the first WRITE cycle.

## Structure
- Package ds_pkg holds:
  - the state enum (IDLE, READ, WRITE, DONE)
  - the ACC_W width function
  - the rounding constant function
- One sub-module, ds_addr_gen, holds the kx/ky/ox/oy counters, the incremental source/destination pointers and the last-pixel/last-block flags. ds_engine holds the FSM, accumulator and memory handshake.

## Test plan
- 4×4 image, F=2, src_base=0x0100, dst_base=0x0200. The top-left block holds 10,11,12,13, and mem_ready is tied high:
  - mem_wdata=12 at address 0x0200 in cycle 5
  - 4 writes total
  - done in cycle 21
- Block all 255 with F=2, and block all 255 with FACTOR_LOG2=3 on an 8×8 image → writes 255, no overflow. Block 0,0,0,1 → 0; block 0,1,1,0 → 1 (rounding).
- img_w=5, img_h=4, F=2:
  - 4 outputs
  - source column 4 never addressed
  - random mem_ready stalls of 0–3 cycles hold address and strobes stable and produce identical results
- img_w=1 with F=2 → done in cycle 1, no mem_rd/mem_wr. start while busy → ignored.
- rst asserted during a stalled WRITE → next cycle all outputs 0 and state IDLE. A fresh start then runs a full correct job.
- src_base=0xFFFE, 4×2 image → source addresses wrap to 0x0000 and beyond.
